// File: rtl/subtractor_serial_if.sv
// Handshake and data bundle for the bit-serial subtractor.
//
// Signals:
//   start  - request to begin a subtraction (driven by master)
//   a, b   - minuend and subtrahend, WIDTH bits (driven by master)
//   b_in   - borrow-in (driven by master)
//   busy   - operation in progress (driven by slave)
//   done   - one-cycle result-valid pulse (driven by slave)
//   diff   - a - b - b_in modulo 2^WIDTH (driven by slave)
//   b_out  - unsigned borrow-out (driven by slave)
//   v_out  - signed two's-complement overflow (driven by slave)
interface subtractor_serial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             v_out;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out, v_out
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out, v_out
    );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// and presents the result with borrow-out and signed overflow in a single
// done cycle. Results hold until the next completed operation.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - subtractor_serial_if slave modport (start/a/b/b_in in,
//          busy/done/diff/b_out/v_out out)
module subtractor_serial #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    subtractor_serial_if.slave bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             brw;
    logic [CNT_W-1:0] cnt;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             b_out_r;
    logic             v_out_r;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             brw_next;

    // One-bit full subtractor on the current LSBs of the operand shifters.
    always_comb begin
        a_bit    = a_sh[0];
        b_bit    = b_sh[0];
        d_bit    = a_bit ^ b_bit ^ brw;
        brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    end

    // Control FSM and datapath. The difference bits are collected in d_sh
    // and only copied to diff_r on the final bit, so partial results never
    // reach the outputs. On the final bit, brw is the borrow into the MSB
    // and brw_next the borrow out of it; their XOR is signed overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            d_sh    <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= '0;
            b_out_r <= 1'b0;
            v_out_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        d_sh   <= '0;
                        brw    <= bus.b_in;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= {d_bit, d_sh[WIDTH-1:1]};
                    brw  <= brw_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        diff_r  <= {d_bit, d_sh[WIDTH-1:1]};
                        b_out_r <= brw_next;
                        v_out_r <= brw ^ brw_next;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.diff  = diff_r;
    assign bus.b_out = b_out_r;
    assign bus.v_out = v_out_r;

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial (WIDTH=4). A timeline model
// predicts busy/done and computes results with integer arithmetic; a compare
// process checks every output on every falling edge. Directed vectors add
// literal expectations for known results, latency and reset behaviour.
module tb_subtractor_serial;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    subtractor_serial_if #(.WIDTH(W)) bus ();

    subtractor_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: phase is cycles since acceptance (-1 when idle).
    // Results come from plain integer subtraction at acceptance time and
    // become visible when the operation is WIDTH edges old.
    int               phase    = -1;
    logic [W-1:0]     exp_diff = '0;
    logic             exp_bout = 1'b0;
    logic             exp_v    = 1'b0;
    logic [W-1:0]     pend_diff;
    logic             pend_bout;
    logic             pend_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    = -1;
            exp_diff = '0;
            exp_bout = 1'b0;
            exp_v    = 1'b0;
        end else if (phase < 0) begin
            if (bus.start === 1'b1) begin
                int ua, ub, ubi, sa, sb, sr;
                ua  = int'(bus.a);
                ub  = int'(bus.b);
                ubi = int'(bus.b_in);
                sa  = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
                sb  = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
                sr  = sa - sb - ubi;
                pend_diff = W'(ua - ub - ubi);
                pend_bout = (ua < ub + ubi);
                pend_v    = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
                phase = 0;
            end
        end else if (phase == W) begin
            phase = -1;
        end else begin
            phase++;
            if (phase == W) begin
                exp_diff = pend_diff;
                exp_bout = pend_bout;
                exp_v    = pend_v;
            end
        end
    end

    // Every-cycle comparison against the model, plus the done-width rule.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        check("busy",  int'(bus.busy),  int'(phase >= 0));
        check("done",  int'(bus.done),  int'(phase == W));
        check("diff",  int'(bus.diff),  int'(exp_diff));
        check("b_out", int'(bus.b_out), int'(exp_bout));
        check("v_out", int'(bus.v_out), int'(exp_v));
        if (prev_done) check("done_width", int'(bus.done), 0);
        prev_done = bus.done;
    end

    // Drive one start pulse; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.b_in  = bi;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts falling edges (starting at 1 for the one after acceptance)
    // until done is seen, bounded.
    task automatic wait_done(output int n, output bit seen);
        n    = 1;
        seen = bus.done;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            seen = bus.done;
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] d,
                               input logic bo, input logic v);
        check({name, ".diff"},  int'(bus.diff),  int'(d));
        check({name, ".b_out"}, int'(bus.b_out), int'(bo));
        check({name, ".v_out"}, int'(bus.v_out), int'(v));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] d, input logic bo, input logic v);
        int  n;
        bit  seen;
        applyStimulus(av, bv, bi);
        wait_done(n, seen);
        check({name, ".done_seen"}, int'(seen), 1);
        check({name, ".latency"}, n, W + 1);
        checkOutput(name, d, bo, v);
        @(negedge clk);
        check({name, ".busy_after"}, int'(bus.busy), 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        int  ndone;
        int  last_cyc;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;

        #1 rst = 1'b1;
        @(negedge clk);
        check("reset.busy", int'(bus.busy), 0);
        check("reset.done", int'(bus.done), 0);
        checkOutput("reset", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] directed vectors");
        run_op("v_2_6_1", 4'd2, 4'd6, 1'b1, 4'b1011, 1'b1, 1'b0);
        run_op("v_7_3_0", 4'd7, 4'd3, 1'b0, 4'b0100, 1'b0, 1'b0);
        run_op("v_7_8_0", 4'd7, 4'd8, 1'b0, 4'b1111, 1'b1, 1'b1);
        run_op("v_8_1_0", 4'd8, 4'd1, 1'b0, 4'b0111, 1'b0, 1'b1);
        run_op("v_0_15_1", 4'd0, 4'd15, 1'b1, 4'b0000, 1'b1, 1'b0);

        $display("[TB] start re-pulse during shift");
        applyStimulus(4'd7, 4'd3, 1'b0);
        @(negedge clk);
        bus.a     = 4'd1;
        bus.b     = 4'd9;
        bus.b_in  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) begin
                ndone++;
                checkOutput("repulse", 4'b0100, 1'b0, 1'b0);
            end
            @(negedge clk);
        end
        check("repulse.done_count", ndone, 1);

        $display("[TB] reset during shift");
        applyStimulus(4'd5, 4'd2, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        bus.start = 1'b1;
        #1;
        check("abort.busy", int'(bus.busy), 0);
        check("abort.done", int'(bus.done), 0);
        checkOutput("abort", 4'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort.no_done", ndone, 0);
        run_op("v_0_0_1", 4'd0, 4'd0, 1'b1, 4'b1111, 1'b1, 1'b0);

        $display("[TB] exhaustive sweep with start held high");
        @(negedge clk);
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        bus.b_in  = 1'b0;
        bus.start = 1'b1;
        ndone     = 0;
        last_cyc  = 0;
        for (int i = 0; i < 512; i++) begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 3 * W) begin
                @(negedge clk);
                n++;
                seen = bus.done;
            end
            check("sweep.done_seen", int'(seen), 1);
            if (seen) begin
                if (i > 0) check("sweep.interval", cyc - last_cyc, W + 2);
                last_cyc = cyc;
                ndone++;
            end
            bus.a    = W'((i + 1) & 15);
            bus.b    = W'(((i + 1) >> 4) & 15);
            bus.b_in = 1'(((i + 1) >> 8) & 1);
        end
        bus.start = 1'b0;
        check("sweep.done_count", ndone, 512);
        repeat (W + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
